// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses {rd,sel}, ExcCodes, exception vectors,
// and the writable Status fields.
package cp0_regfile_pkg;

  localparam logic [7:0] CR_BADVADDR = 8'h40;
  localparam logic [7:0] CR_COUNT    = 8'h48;
  localparam logic [7:0] CR_COMPARE  = 8'h58;
  localparam logic [7:0] CR_STATUS   = 8'h60;
  localparam logic [7:0] CR_CAUSE    = 8'h68;
  localparam logic [7:0] CR_EPC      = 8'h70;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exccode_e;

  localparam logic [31:0] VEC_BEV1 = 32'hBFC00380;
  localparam logic [31:0] VEC_BEV0 = 32'h80000180;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV clocks, TI latches
// when a tick brings Count onto Compare and stays set until Compare is rewritten.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int            DW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (div == DIV_LAST);
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) count <= count_inc;
      end
      // A Compare write clears TI even if a match happens on the same edge.
      if (compare_we)
        ti <= 1'b0;
      else if (tick && !count_we && count_inc == compare)
        ti <= 1'b1;
      if (compare_we) compare <= wdata;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file beside WB: Status/Cause/EPC/BadVAddr plus optional timer.
// Define CP0_TIMER_EN to build Count/Compare and the timer interrupt.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int COUNT_DIV = 2,
  parameter int EXT_INT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mtc0_we,
  input  logic [7:0]           c0_waddr,
  input  logic [31:0]          c0_wdata,
  input  logic [7:0]           c0_raddr,
  output logic [31:0]          c0_rdata,
  input  logic                 wb_ex,
  input  logic [4:0]           wb_excode,
  input  logic                 wb_bd,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 eret_flush,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  output logic                 int_req,
  output logic [31:0]          ex_entry,
  output logic [31:0]          epc_out
);
  localparam logic BEV = 1'b1;

  status_t     status;
  logic        bd;
  logic [4:0]  exccode;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [5:0]  ext_pad;
  logic [7:0]  ip;
  logic [31:0] epc, badvaddr, count, compare;
  logic        ti;
  logic        sw_wr;

  // An exception or ERET in WB squashes the MTC0 that would commit alongside it.
  assign sw_wr   = mtc0_we & ~wb_ex & ~eret_flush;
  assign ext_pad = 6'(ext_int_in);

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (sw_wr && c0_waddr == CR_COUNT),
    .compare_we (sw_wr && c0_waddr == CR_COMPARE),
    .wdata      (c0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  logic [4:0] unused_div;
  assign unused_div = 5'(COUNT_DIV);
  assign count      = '0;
  assign compare    = '0;
  assign ti         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      status   <= '0;
      bd       <= 1'b0;
      exccode  <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= ext_pad;
      if (wb_ex) begin
        status.exl <= 1'b1;
        exccode    <= wb_excode;
        // Nested exceptions keep the original return point.
        if (!status.exl) begin
          bd  <= wb_bd;
          epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
        end
        if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES) badvaddr <= wb_badvaddr;
      end else if (eret_flush) begin
        status.exl <= 1'b0;
      end else if (sw_wr) begin
        case (c0_waddr)
          CR_STATUS: status <= '{im: c0_wdata[15:8], exl: c0_wdata[1], ie: c0_wdata[0]};
          CR_CAUSE:  ip_sw  <= c0_wdata[9:8];
          CR_EPC:    epc    <= c0_wdata;
          default:   ;
        endcase
      end
    end
  end

  assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

  always_comb begin
    c0_rdata = '0;
    case (c0_raddr)
      CR_BADVADDR: c0_rdata = badvaddr;
      CR_COUNT:    c0_rdata = count;
      CR_COMPARE:  c0_rdata = compare;
      CR_STATUS:   c0_rdata = {9'b0, BEV, 6'b0, status.im, 6'b0, status.exl, status.ie};
      CR_CAUSE:    c0_rdata = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
      CR_EPC:      c0_rdata = epc;
      default:     c0_rdata = '0;
    endcase
  end

  assign int_req  = status.ie & ~status.exl & |(ip & status.im);
  assign ex_entry = BEV ? VEC_BEV1 : VEC_BEV0;
  assign epc_out  = epc;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomised + directed bench for cp0_regfile against a word-level CP0 model.
// Timer checks follow whether CP0_TIMER_EN is defined for the build.
module tb_cp0_regfile;
  localparam int DIV = 2;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mtc0_we = 1'b0;
  logic [7:0]  c0_waddr = '0, c0_raddr = '0;
  logic [31:0] c0_wdata = '0, c0_rdata;
  logic        wb_ex = 1'b0, wb_bd = 1'b0, eret_flush = 1'b0;
  logic [4:0]  wb_excode = '0;
  logic [31:0] wb_pc = '0, wb_badvaddr = '0;
  logic [5:0]  ext_int_in = '0;
  logic        int_req;
  logic [31:0] ex_entry, epc_out;

  cp0_regfile #(.COUNT_DIV(DIV), .EXT_INT_W(6)) dut (
    .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .c0_waddr(c0_waddr), .c0_wdata(c0_wdata),
    .c0_raddr(c0_raddr), .c0_rdata(c0_rdata), .wb_ex(wb_ex), .wb_excode(wb_excode),
    .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .ext_int_in(ext_int_in), .int_req(int_req), .ex_entry(ex_entry), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit armed = 1'b0;

  // Model state, kept as plain words and counters.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_cmp, m_base;
  int          m_edges;  // clock edges since Count was last loaded

  function automatic logic [31:0] m_count();
    return TIMER ? m_base + 32'(m_edges / DIV) : 32'd0;
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40: return m_badv;
      8'h48: return m_count();
      8'h58: return TIMER ? m_cmp : 32'd0;
      8'h60: return 32'h00400000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      8'h68: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
      8'h70: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic eff;
    int   ne;
    logic [31:0] nc;
    if (reset) begin
      m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = '0; m_hw = '0;
      m_exc = '0; m_epc = '0; m_badv = '0; m_cmp = '0; m_base = '0; m_edges = 0;
      return;
    end
    eff = mtc0_we && !wb_ex && !eret_flush;
    if (TIMER) begin
      ne = m_edges + 1;
      nc = m_base + 32'(ne / DIV);
      if (eff && c0_waddr == 8'h58) begin m_cmp = c0_wdata; m_ti = 0; end
      else if ((ne % DIV) == 0 && nc == m_cmp && !(eff && c0_waddr == 8'h48)) m_ti = 1;
      if (eff && c0_waddr == 8'h48) begin m_base = c0_wdata; m_edges = 0; end
      else m_edges = ne;
    end
    m_hw = ext_int_in;
    if (wb_ex) begin
      if (!m_exl) begin m_bd = wb_bd; m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc; end
      m_exl = 1; m_exc = wb_excode;
      if (wb_excode == 5'd4 || wb_excode == 5'd5) m_badv = wb_badvaddr;
    end else if (eret_flush) m_exl = 0;
    else if (eff) begin
      case (c0_waddr)
        8'h60: begin m_im = c0_wdata[15:8]; m_exl = c0_wdata[1]; m_ie = c0_wdata[0]; end
        8'h68: m_ipsw = c0_wdata[9:8];
        8'h70: m_epc = c0_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("rdata", c0_rdata, m_read(c0_raddr));
    chk("int_req", 32'(int_req), 32'(m_ie && !m_exl && ((m_ip() & m_im) != 0)));
    chk("ex_entry", ex_entry, 32'hBFC00380);
    chk("epc_out", epc_out, m_epc);
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    mtc0_we = 0; wb_ex = 0; eret_flush = 0; reset = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    idle(); mtc0_we = 1; c0_waddr = a; c0_wdata = d; cyc(); idle();
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    c0_raddr = a; #1; chk(name, c0_rdata, exp);
  endtask

  logic [7:0] addrs [7];
  logic [4:0] codes [7];

  initial begin
    addrs = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    reset = 1; cyc(); cyc(); armed = 1; idle();

    // Reset values
    rd("rst_badv", 8'h40, 0); rd("rst_count", 8'h48, 0); rd("rst_cmp", 8'h58, 0);
    rd("rst_status", 8'h60, 32'h00400000); rd("rst_cause", 8'h68, 0); rd("rst_epc", 8'h70, 0);
    chk("rst_int_req", 32'(int_req), 0);

    // Delay-slot AdEL, then a nested exception
    wb_ex = 1; wb_excode = 5'd4; wb_bd = 1; wb_pc = 32'hBFC00104; wb_badvaddr = 32'h3;
    cyc();
    wb_excode = 5'd8; wb_bd = 0; wb_pc = 32'h12345678; wb_badvaddr = 32'hDEADBEEF;
    rd("ds_epc", 8'h70, 32'hBFC00100); rd("ds_cause", 8'h68, 32'h80000010);
    rd("ds_badv", 8'h40, 32'h3); rd("ds_status", 8'h60, 32'h00400002);
    cyc(); idle();
    rd("nest_epc", 8'h70, 32'hBFC00100); rd("nest_cause", 8'h68, 32'h80000020);
    rd("nest_badv", 8'h40, 32'h3);

    // Interrupt masking through IM[2] / ext_int_in[0]
    eret_flush = 1; cyc(); idle();
    wr(8'h60, 32'h00000401);
    ext_int_in = 6'b000001; #1;
    chk("irq_before", 32'(int_req), 0);
    cyc();
    chk("irq_after", 32'(int_req), 1);
    wb_ex = 1; wb_excode = 5'd0; wb_pc = 32'h100; cyc(); idle();
    chk("irq_exl", 32'(int_req), 0);

    // wb_ex beats a same-cycle MTC0 clearing EXL
    eret_flush = 1; cyc(); idle();
    wb_ex = 1; wb_excode = 5'd8; wb_pc = 32'h200; mtc0_we = 1; c0_waddr = 8'h60; c0_wdata = 32'h401;
    cyc(); idle();
    c0_raddr = 8'h60; #1; chk("simul_exl", 32'(c0_rdata[1]), 1);

    ext_int_in = '0;
    eret_flush = 1; cyc(); idle();
`ifdef CP0_TIMER_EN
    wr(8'h60, 32'h00008001);
    wr(8'h58, 32'd10);
    wr(8'h48, 32'd0);
    for (int i = 0; i < 19; i++) cyc();
    rd("tmr_cnt9", 8'h48, 32'd9);
    c0_raddr = 8'h68; #1; chk("tmr_ti_early", 32'(c0_rdata[30]), 0);
    chk("tmr_irq_early", 32'(int_req), 0);
    cyc();
    rd("tmr_cnt10", 8'h48, 32'd10);
    c0_raddr = 8'h68; #1; chk("tmr_ti", 32'(c0_rdata[30]), 1);
    chk("tmr_irq", 32'(int_req), 1);
    wr(8'h58, 32'd100);
    c0_raddr = 8'h68; #1; chk("tmr_ti_clr", 32'(c0_rdata[30]), 0);
`else
    wr(8'h60, 32'h00008001);
    wr(8'h48, 32'd5);
    rd("notmr_count", 8'h48, 32'd0);
    wr(8'h58, 32'd3);
    rd("notmr_cmp", 8'h58, 32'd0);
    for (int i = 0; i < 1000; i++) cyc();
    c0_raddr = 8'h68; #1; chk("notmr_ti", 32'(c0_rdata[30]), 0);
    chk("notmr_irq", 32'(int_req), 0);
`endif

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      mtc0_we    = ($urandom_range(0, 3) == 0);
      c0_waddr   = addrs[$urandom_range(0, 6)];
      c0_wdata   = $urandom();
      if ($urandom_range(0, 1) == 0) c0_wdata[31:16] = '0;
      if (c0_waddr == 8'h48 || c0_waddr == 8'h58) c0_wdata = 32'($urandom_range(0, 40));
      c0_raddr   = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : addrs[$urandom_range(0, 5)];
      wb_ex      = ($urandom_range(0, 15) == 0);
      wb_excode  = codes[$urandom_range(0, 6)];
      wb_bd      = $urandom_range(0, 1);
      wb_pc      = $urandom();
      wb_badvaddr = $urandom();
      eret_flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ext_int_in = 6'($urandom());
      cyc();
    end
    idle(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
